// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for the bit-serial adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    // Producer/consumer side: drives operands and result acceptance.
    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  busy
    );

    // Adder side.
    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output busy
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one full-adder cell
// with a registered carry. One bit per clock; result held until consumed.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_adder_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             out_valid_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    logic             s_c;
    logic             co_c;
    logic [WIDTH-1:0] acc_next_c;

    // Full-adder cell on the current LSBs; acc_next_c is the sum-so-far with this bit at the top.
    always_comb begin
        s_c        = a_sh[0] ^ b_sh[0] ^ carry;
        co_c       = (a_sh[0] & b_sh[0]) | (b_sh[0] & carry) | (a_sh[0] & carry);
        acc_next_c = {s_c, acc};
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

    // Control FSM and datapath: accept, shift WIDTH bits, hold result until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            acc         <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                        acc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= co_c;
                    acc   <= acc_next_c[WIDTH-1:1];
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    if (cnt == CW'(WIDTH - 1)) begin
                        // Last bit: carry still holds the carry into the MSB here.
                        cnt         <= '0;
                        sum_q       <= acc_next_c;
                        cout_q      <= co_c;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q       <= carry ^ co_c;
`endif
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // New operands are not taken here, even with in_valid high.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
